bus_xfer_ctrl: RTL and testbench
================================

Name: bus_xfer_ctrl

Overview:
- Initiator side of the 8-bit shared data bus: drives the one-hot source-output-enable and destination-write-enable lines that the bus router consumes.
- Accepts transfer commands (source, destination, burst length) over a valid/ready handshake.
- Each beat reads from the source into a holding register, then writes to the destination.
- Sits between the instruction decoder and the bus endpoints (registers, I/O ports).

Parameters:
- DATA_W, 8, bus data width.
- N_PORTS, 3, number of bus endpoints; valid select indices are 0..N_PORTS-1.
- SEL_W, 2, width of src/dst select fields.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  command valid.
- req_ready  out  1  controller can accept a command.
- req_src  in  SEL_W  source endpoint index.
- req_dst  in  SEL_W  destination endpoint index.
- req_len  in  4  burst length minus one (0 = 1 beat, 15 = 16 beats).
- src_oe  out  N_PORTS  one-hot source output enable.
- bus_rd_data  in  DATA_W  data presented on the bus by the enabled source.
- dst_we  out  N_PORTS  one-hot destination write enable.
- bus_wr_data  out  DATA_W  data driven to the destination.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse on the last write beat of a command.
- err  out  1  one-cycle pulse when a command has an illegal select.

Behaviour:
- Reset (async, immediate): state=IDLE, src_oe=0, dst_we=0, bus_wr_data=0, holding reg=0, beat counter=0, done=0, err=0, busy=0.
- req_ready = (state==IDLE) && rst_n. A command is accepted on a rising edge with req_valid && req_ready; src, dst and len are latched at acceptance.
- States: IDLE, READ, WRITE, ERR.
- IDLE -> READ on an accepted legal command.
- IDLE -> ERR on an accepted command with src>=N_PORTS or dst>=N_PORTS.
- READ:
  - src_oe[src]=1 for exactly one cycle.
  - bus_rd_data is captured into the holding reg at the end of the cycle.
  - -> WRITE.
- WRITE:
  - dst_we[dst]=1 for one cycle; bus_wr_data = holding reg.
  - If beat counter==len: done=1 this cycle, counter cleared, -> IDLE.
  - Otherwise: counter+1, -> READ.
- ERR:
  - err=1 for one cycle; no enables asserted; -> IDLE.
- Outputs are registered Moore decodes of state, with no combinational path from req_* to enables.
- Latency: acceptance at edge N, then src_oe during cycle N+1 and dst_we during cycle N+2. A burst of L+1 beats occupies 2(L+1) cycles; req_ready returns in the cycle after done.
- src_oe and dst_we are never high in the same cycle. At most one bit of each is set.
- src==dst is legal (read-modify-in-place copy) and follows the normal sequence.
- req_valid while busy is ignored and has no effect on the latched command.
- bus_wr_data holds its last value outside WRITE.
- Reset mid-burst: enables drop immediately, no done pulse, the partial burst is discarded.

Optional Feature:
- Macro BUS_XFER_STATS_EN.
- When defined:
  - adds output xfer_cnt [7:0], the count of completed write beats;
  - increments on every dst_we cycle and wraps 255->0;
  - reset to 0;
  - is not affected by ERR commands.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Single beat: after reset, src=0, dst=1, len=0, bus_rd_data=8'hA5 -> src_oe=3'b001 in cycle 1, dst_we=3'b010 with bus_wr_data=8'hA5 and done=1 in cycle 2, req_ready=1 in cycle 3.
- Burst: src=2, dst=0, len=3, bus_rd_data stepping 8'h10,11,12,13 on READ cycles -> four WRITE cycles with dst_we=3'b001 and data 10,11,12,13; done only on the 4th write; busy high for 8 cycles.
- Illegal select: src=3, dst=0 -> err=1 one cycle, src_oe=dst_we=0 throughout, back to IDLE next cycle.
- Backpressure: req_valid held high with new src/dst during a burst -> latched command unchanged; the new command is accepted only when req_ready=1.
- Async reset mid-burst: assert rst_n=0 during WRITE of beat 2 of len=5 -> dst_we=0 immediately, no done, IDLE after release.
- With BUS_XFER_STATS_EN: 300 single-beat transfers -> xfer_cnt reads 44 (300 mod 256); an ERR command leaves it unchanged.

Source files
------------

// File: rtl/bus_xfer_ctrl.sv
// Initiator for the shared data bus: each command runs READ/WRITE beat pairs through a holding register.
// Define BUS_XFER_STATS_EN to add xfer_cnt, a wrapping count of completed write beats.
module bus_xfer_ctrl #(
   parameter int DATA_W  = 8,
   parameter int N_PORTS = 3,
   parameter int SEL_W   = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [SEL_W-1:0]   req_src,
   input  logic [SEL_W-1:0]   req_dst,
   input  logic [3:0]         req_len,
   output logic [N_PORTS-1:0] src_oe,
   input  logic [DATA_W-1:0]  bus_rd_data,
   output logic [N_PORTS-1:0] dst_we,
   output logic [DATA_W-1:0]  bus_wr_data,
   output logic               busy,
   output logic               done,
   output logic               err
`ifdef BUS_XFER_STATS_EN
   ,
   output logic [7:0]         xfer_cnt
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_ERR} state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [SEL_W-1:0]  r_src;
   logic [SEL_W-1:0]  r_dst;
   logic [3:0]        r_len;
   logic [3:0]        r_cnt;
   logic [DATA_W-1:0] r_hold;
   logic              w_accept;
   logic              w_legal;
   logic              w_last;

   assign req_ready = (r_state == S_IDLE) && rst_n;
   assign w_accept  = req_valid && req_ready;
   assign w_legal   = (int'(req_src) < N_PORTS) && (int'(req_dst) < N_PORTS);
   assign w_last    = (r_cnt == r_len);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_next = w_legal ? S_READ : S_ERR;
         S_READ:  w_state_next = S_WRITE;
         S_WRITE: w_state_next = w_last ? S_IDLE : S_READ;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Command fields are only sampled at acceptance, so req_* while busy cannot disturb a burst.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_src  <= '0;
         r_dst  <= '0;
         r_len  <= '0;
         r_cnt  <= '0;
         r_hold <= '0;
      end else begin
         if (w_accept) begin
            r_src <= req_src;
            r_dst <= req_dst;
            r_len <= req_len;
            r_cnt <= '0;
         end
         if (r_state == S_READ) begin
            r_hold <= bus_rd_data;
         end
         if (r_state == S_WRITE) begin
            r_cnt <= w_last ? 4'd0 : r_cnt + 4'd1;
         end
      end
   end

   for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_sel
      assign src_oe[gi] = (r_state == S_READ)  && (int'(r_src) == gi);
      assign dst_we[gi] = (r_state == S_WRITE) && (int'(r_dst) == gi);
   end

   assign bus_wr_data = r_hold;
   assign busy        = (r_state != S_IDLE);
   assign done        = (r_state == S_WRITE) && w_last;
   assign err         = (r_state == S_ERR);

`ifdef BUS_XFER_STATS_EN
   logic [7:0] r_xfer_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_xfer_cnt <= '0;
      end else if (r_state == S_WRITE) begin
         r_xfer_cnt <= r_xfer_cnt + 8'd1;
      end
   end

   assign xfer_cnt = r_xfer_cnt;
`endif

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Self-checking bench for bus_xfer_ctrl: a beat-position model checked every cycle plus directed literal checks.
module tb_bus_xfer_ctrl;

   localparam int NP = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [1:0] req_src = '0;
   logic [1:0] req_dst = '0;
   logic [3:0] req_len = '0;
   logic [2:0] src_oe;
   logic [7:0] bus_rd_data = '0;
   logic [2:0] dst_we;
   logic [7:0] bus_wr_data;
   logic       busy;
   logic       done;
   logic       err;
`ifdef BUS_XFER_STATS_EN
   logic [7:0] xfer_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   bus_xfer_ctrl dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_src(req_src), .req_dst(req_dst), .req_len(req_len),
      .src_oe(src_oe), .bus_rd_data(bus_rd_data), .dst_we(dst_we),
      .bus_wr_data(bus_wr_data), .busy(busy), .done(done), .err(err)
`ifdef BUS_XFER_STATS_EN
      , .xfer_cnt(xfer_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a command is a sequence of 2*(len+1) cycles; even positions read, odd positions write.
   logic       m_active = 1'b0;
   logic       m_err = 1'b0;
   int         m_k = 0;
   logic [1:0] m_src = '0;
   logic [1:0] m_dst = '0;
   int         m_len = 0;
   logic [7:0] m_hold = '0;
   logic [7:0] m_cnt = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active <= 1'b0;
         m_err    <= 1'b0;
         m_k      <= 0;
         m_hold   <= '0;
         m_cnt    <= '0;
      end else if (m_err) begin
         m_err <= 1'b0;
      end else if (m_active) begin
         if (m_k % 2 == 0) begin
            m_hold <= bus_rd_data;
         end else begin
            m_cnt <= m_cnt + 8'd1;
            if (m_k / 2 == m_len) m_active <= 1'b0;
         end
         m_k <= m_k + 1;
      end else if (req_valid) begin
         if (int'(req_src) >= NP || int'(req_dst) >= NP) begin
            m_err <= 1'b1;
         end else begin
            m_active <= 1'b1;
            m_k      <= 0;
            m_src    <= req_src;
            m_dst    <= req_dst;
            m_len    <= int'(req_len);
         end
      end
   end

   initial begin
      logic [2:0] one;
      logic       idle;
      one = 3'b001;
      @(negedge rst_n);
      forever begin
         @(negedge clk);
         idle = !m_active && !m_err;
         chk("ready", int'(req_ready), int'(rst_n && idle));
         chk("busy", int'(busy), int'(!idle));
         chk("err", int'(err), int'(m_err));
         chk("src_oe", int'(src_oe), (m_active && m_k % 2 == 0) ? int'(one << m_src) : 0);
         chk("dst_we", int'(dst_we), (m_active && m_k % 2 == 1) ? int'(one << m_dst) : 0);
         chk("done", int'(done), int'(m_active && m_k % 2 == 1 && m_k / 2 == m_len));
         chk("wr_data", int'(bus_wr_data), int'(m_hold));
`ifdef BUS_XFER_STATS_EN
         chk("xfer_cnt", int'(xfer_cnt), int'(m_cnt));
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic issue(input logic [1:0] s, input logic [1:0] d, input logic [3:0] l);
      req_valid = 1'b1;
      req_src   = s;
      req_dst   = d;
      req_len   = l;
      step();
      req_valid = 1'b0;
   endtask

   initial begin
      int busy_cycles;
      bit seen;
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("rst_src_oe", int'(src_oe), 0);
      chk("rst_dst_we", int'(dst_we), 0);
      chk("rst_wr_data", int'(bus_wr_data), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done_err", int'({done, err}), 0);
      chk("rst_ready", int'(req_ready), 0);
      step();
      rst_n = 1'b1;

      // Single beat 0 -> 1
      bus_rd_data = 8'hA5;
      issue(2'd0, 2'd1, 4'd0);
      @(negedge clk);
      chk("sb_src_oe", int'(src_oe), 3'b001);
      @(negedge clk);
      chk("sb_dst_we", int'(dst_we), 3'b010);
      chk("sb_data", int'(bus_wr_data), 8'hA5);
      chk("sb_done", int'(done), 1);
      @(negedge clk);
      chk("sb_ready", int'(req_ready), 1);
      step();

      // Burst 2 -> 0, four beats
      issue(2'd2, 2'd0, 4'd3);
      busy_cycles = 0;
      for (int b = 0; b < 4; b++) begin
         bus_rd_data = 8'h10 + 8'(b);
         @(negedge clk);
         chk("bu_src_oe", int'(src_oe), 3'b100);
         busy_cycles += int'(busy);
         step();
         @(negedge clk);
         chk("bu_dst_we", int'(dst_we), 3'b001);
         chk("bu_data", int'(bus_wr_data), 8'h10 + b);
         chk("bu_done", int'(done), int'(b == 3));
         busy_cycles += int'(busy);
         step();
      end
      chk("bu_busy_cycles", busy_cycles, 8);
      @(negedge clk);
      chk("bu_idle", int'(busy), 0);
      step();

      // Illegal source select
      issue(2'd3, 2'd0, 4'd0);
      @(negedge clk);
      chk("il_err", int'(err), 1);
      chk("il_enables", int'({src_oe, dst_we}), 0);
      @(negedge clk);
      chk("il_err_clear", int'(err), 0);
      chk("il_ready", int'(req_ready), 1);
      step();

      // Backpressure: a new command is held on req_* throughout a 3-beat burst
      bus_rd_data = 8'h3C;
      issue(2'd0, 2'd2, 4'd2);
      req_valid = 1'b1;
      req_src   = 2'd1;
      req_dst   = 2'd1;
      req_len   = 4'd0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk("bp_done_seen", int'(seen), 1);
      chk("bp_dst_we", int'(dst_we), 3'b100);
      @(negedge clk);
      chk("bp_ready", int'(req_ready), 1);
      step();
      req_valid = 1'b0;
      @(negedge clk);
      chk("bp_new_src_oe", int'(src_oe), 3'b010);
      step();
      step();

      // Asynchronous reset during the second write beat of a 6-beat burst
      issue(2'd1, 2'd2, 4'd5);
      repeat (3) step();
      chk("ar_pre_we", int'(dst_we), 3'b100);
      rst_n = 1'b0;
      #1;
      chk("ar_we_drop", int'(dst_we), 0);
      chk("ar_no_done", int'(done), 0);
      chk("ar_busy", int'(busy), 0);
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("ar_ready", int'(req_ready), 1);
      chk("ar_idle", int'(busy), 0);
      step();

`ifdef BUS_XFER_STATS_EN
      for (int n = 0; n < 300; n++) begin
         bus_rd_data = 8'(n);
         issue(2'd0, 2'd1, 4'd0);
         step();
         step();
      end
      chk("st_cnt_300", int'(xfer_cnt), 44);
      issue(2'd0, 2'd3, 4'd0);
      step();
      chk("st_cnt_err", int'(xfer_cnt), 44);
      step();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
